// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS hazard scheduler: use/new times, forward selects
// and the shadow pipeline-stage records.
package mips_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
        logic       reg_write;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] wr;
        logic       reg_write;
        logic [1:0] tnew;
    } m_stage_t;

    typedef struct packed {
        logic [4:0] wr;
        logic       reg_write;
    } w_stage_t;

    // One stage closer to the result: saturating decrement of Tnew.
    function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
        case (tnew)
            TNEW_LOAD: tnew_age = TNEW_ALU;
            TNEW_ALU:  tnew_age = TNEW_LINK;
            TNEW_LINK: tnew_age = TNEW_LINK;
            default:   tnew_age = tnew - 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scheduler_md_sched.sv
// Mult/div scheduler: busy countdown started from the E stage and the
// interlock that holds HI/LO users in D while the unit is occupied.
module md_sched
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_md_start,
    input  logic i_md_div,
    input  logic i_md_use,
    output logic o_md_busy,
    output logic o_stall_md
);

    logic [3:0] r_count;
    logic       r_busy;
    logic [3:0] w_count_nxt;

    always_comb begin
        // NOTE: default assigned first so this combinational block cannot infer a latch.
        w_count_nxt = r_count;
        if (i_md_start) begin
            w_count_nxt = i_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (r_count != 4'd0) begin
            w_count_nxt = r_count - 4'd1;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt != 4'd0);
        end
    end

    // The start itself blocks users during its E cycle, before busy rises.
    assign o_md_busy  = r_busy;
    assign o_stall_md = i_md_use & (r_busy | i_md_start);

endmodule

// File: rtl/hazard_scheduler.sv
// Central hazard controller for the 5-stage MIPS pipeline: stall, flush and
// forward selects plus mult/div scheduling. Optional stall counters: HAZARD_STATS_EN.
module hazard_scheduler
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic [1:0] TnewD,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] wrD,
    input  logic       RegWriteD,
    input  logic       md_startD,
    input  logic       md_divD,
    input  logic       md_useD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    e_stage_t r_e;
    m_stage_t r_m;
    w_stage_t r_w;

    e_stage_t w_e_nxt;
    logic     w_stall_rs;
    logic     w_stall_rt;
    logic     w_stall_md;
    logic     w_stall;

    // A producer blocks D while its result is further away than the consumer's use time.
    function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input e_stage_t e, input m_stage_t m);
        reg_hazard = (src != 5'd0) && (tuse != TUSE_NONE) &&
                     ((e.reg_write && (e.wr == src) && (tuse < e.tnew)) ||
                      (m.reg_write && (m.wr == src) && (tuse < m.tnew)));
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src, input m_stage_t m,
                                         input w_stage_t w);
        if (src == 5'd0)
            return FWD_REG;
        if (m.reg_write && (m.wr == src) && (m.tnew == TNEW_LINK))
            return FWD_M;
        if (w.reg_write && (w.wr == src))
            return FWD_W;
        return FWD_REG;
    endfunction

    assign w_e_nxt = '{rs: rsD, rt: rtD, wr: wrD, reg_write: RegWriteD,
                       tnew: TnewD, md_start: md_startD, md_div: md_divD};

    md_sched #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_sched (
        .clk        (clk),
        .reset      (reset),
        .i_md_start (r_e.md_start),
        .i_md_div   (r_e.md_div),
        .i_md_use   (md_useD),
        .o_md_busy  (md_busy),
        .o_stall_md (w_stall_md)
    );

    assign w_stall_rs = reg_hazard(rsD, Tuse_rs, r_e, r_m);
    assign w_stall_rt = reg_hazard(rtD, Tuse_rt, r_e, r_m);
    assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

    assign stallF = w_stall;
    assign stallD = w_stall;
    assign flushE = w_stall;

    assign forwardAD = (rsD != 5'd0) && r_m.reg_write && (r_m.wr == rsD) && (r_m.tnew == TNEW_LINK);
    assign forwardBD = (rtD != 5'd0) && r_m.reg_write && (r_m.wr == rtD) && (r_m.tnew == TNEW_LINK);
    assign forwardAE = fwd_e(r_e.rs, r_m, r_w);
    assign forwardBE = fwd_e(r_e.rt, r_m, r_w);

    // A stalled D instruction leaves a bubble in E instead of advancing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_e <= w_stall ? '0 : w_e_nxt;
            r_m <= '{wr: r_e.wr, reg_write: r_e.reg_write, tnew: tnew_age(r_e.tnew)};
            r_w <= '{wr: r_m.wr, reg_write: r_m.reg_write};
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_md_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt    <= 32'd0;
            r_md_stall_cnt <= 32'd0;
        end else begin
            r_stall_cnt    <= r_stall_cnt + {31'd0, w_stall};
            r_md_stall_cnt <= r_md_stall_cnt + {31'd0, w_stall_md};
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign md_stall_cnt = r_md_stall_cnt;
`endif

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Central hazard controller for the 5-stage MIPS pipeline.
- Takes per-instruction Tuse/Tnew, register addresses and RegWrite from the decode stage, and tracks them through its own shadow E/M/W registers.
- Produces stall, flush and forward selects for all stages.
- Also schedules the multi-cycle mult/div unit: a busy countdown plus interlocks for HI/LO users.

Parameters:
- MULT_CYCLES, 5: E-stage busy cycles for mult/multu.
- DIV_CYCLES, 10: E-stage busy cycles for div/divu.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low reset
- Tuse_rs  in  2  D-stage rs use time; 3 = rs not read
- Tuse_rt  in  2  D-stage rt use time; 3 = rt not read
- TnewD  in  2  cycles after E-entry until result exists (0 link, 1 ALU, 2 load)
- rsD  in  5  D-stage rs
- rtD  in  5  D-stage rt
- wrD  in  5  D-stage destination, after RegDst mux
- RegWriteD  in  1  D-stage writes GRF
- md_startD  in  1  D instr is mult/div
- md_divD  in  1  1 = div family, 0 = mult family
- md_useD  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- stallF  out  1  hold PC
- stallD  out  1  hold F/D register
- flushE  out  1  load bubble into D/E register
- forwardAD  out  1  D rs takes ALUoutM
- forwardBD  out  1  D rt takes ALUoutM
- forwardAE  out  2  E rs source: 00 reg, 01 W result, 10 ALUoutM
- forwardBE  out  2  E rt source, same encoding
- md_busy  out  1  mult/div unit computing

Behaviour:
- Shadow stage registers, reset to 0 and updated every cycle:
  - E: rs, rt, wr, RegWrite, Tnew, md_start, md_div.
  - M: wr, RegWrite, Tnew.
  - W: wr, RegWrite.
- Advance rules:
  - D->E copies D fields when not stalled; on stall E loads a bubble (all zero).
  - E->M copies always, with TnewM = (TnewE==0) ? 0 : TnewE-1.
  - W is always Tnew 0.
- Register hazard (combinational): for rs, stall_rs = rsD!=0 and Tuse_rs!=3 and any of:
  - RegWriteE and wrE==rsD and Tuse_rs < TnewE;
  - RegWriteM and wrM==rsD and Tuse_rs < TnewM.
  - The same rule applies to rt.
- MD hazard: stall_md = md_useD and (md_busy or md_startE).
- stall = stall_rs | stall_rt | stall_md; stallF = stallD = flushE = stall.
- D forwarding: forwardAD = rsD!=0 and RegWriteM and wrM==rsD and TnewM==0; forwardBD is the same for rtD.
- E forwarding: the 10 case (M match, TnewM==0) has priority over the 01 case (W match); register 0 never forwards.
- MD counter, 4 bits, reset 0:
  - loads MULT_CYCLES or DIV_CYCLES on the cycle md_startE is set;
  - otherwise decrements while nonzero.
  - md_busy = counter!=0, registered.
  - A start while busy cannot occur, because stall_md blocks it.
- Reset (reset==0 at a clk edge):
  - all shadow state and the counter clear;
  - mid-operation reset aborts a running mult/div;
  - outputs are 0 in the cycle after reset.
- Latency:
  - stall/forward outputs are combinational from inputs plus current shadow state;
  - md_busy rises one cycle after the start reaches E.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - adds output stall_cnt [31:0], counting cycles with stall==1;
  - adds output md_stall_cnt [31:0], counting cycles with stall_md==1;
  - both clear on reset and wrap at 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - TUSE_NONE=3;
  - TNEW_LINK=0, TNEW_ALU=1, TNEW_LOAD=2;
  - FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module, md_sched, holds the mult/div counter, busy flag and stall_md logic.

Test Plan:
- Load-use: lw $1 in E (TnewE=2, wrE=1) with add in D (rsD=1, Tuse_rs=1) -> stall=1 for exactly 1 cycle; next cycle forwardAE=01.
- ALU-branch: add $2 in E (TnewE=1) with beq in D (rsD=2, Tuse_rs=0) -> 1-cycle stall; then forwardAD=1 with add in M.
- Zero-register and priority: wrE=0 with RegWriteE=1 and rsD=0 -> no stall and no forward. M and W both writing $5 -> forwardAE=10.
- Mult/div busy: div in E, mfhi follows -> md_busy high for 10 cycles; mfhi stalls for 11 cycles (E-entry cycle plus busy), then proceeds. mult gives 5 busy cycles.
- Reset mid-div: reset=0 for 1 cycle at busy count 4 -> md_busy=0, all outputs 0, shadow registers cleared.
- HAZARD_STATS_EN: run the load-use and div sequences -> stall_cnt=12, md_stall_cnt=11.
